// File: rtl/morse_symbol_classifier.sv
// ---------------------------------------------------------------------------
// morse_symbol_classifier
//
// Purpose:
//   First timing stage after key synchronization. Debounces the synchronized
//   key level, measures each press and each release, and emits dot/dash
//   symbol events plus letter-end and word-end markers for the decoder.
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous, active-high reset (synchronous release
//                        is provided upstream)
//   key_i           in   synchronized key level, 1 = pressed
//   symbol_valid_o  out  one-cycle pulse: a symbol completed
//   symbol_dash_o   out  classifies the last symbol (1 = dash, 0 = dot);
//                        holds its value until the next symbol
//   letter_end_o    out  one-cycle pulse: letter gap elapsed after a symbol
//   word_end_o      out  one-cycle pulse: word gap elapsed after a letter end
// ---------------------------------------------------------------------------
module morse_symbol_classifier #(
   parameter int DEBOUNCE_CLKS   = 4,
   parameter int DASH_CLKS       = 12,
   parameter int LETTER_GAP_CLKS = 12,
   parameter int WORD_GAP_CLKS   = 28,
   parameter int CNT_WIDTH       = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic key_i,
   output logic symbol_valid_o,
   output logic symbol_dash_o,
   output logic letter_end_o,
   output logic word_end_o
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS       = 2'd1,
      GAP         = 2'd2,
      LETTER_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CLKS - 1);
   localparam logic [CNT_WIDTH-1:0] DASH_TH   = CNT_WIDTH'(DASH_CLKS);
   localparam logic [CNT_WIDTH-1:0] LETTER_TH = CNT_WIDTH'(LETTER_GAP_CLKS);
   localparam logic [CNT_WIDTH-1:0] WORD_TH   = CNT_WIDTH'(WORD_GAP_CLKS);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;

   // Saturating increment: counters stick at all-ones instead of wrapping,
   // so a very long press still classifies as a dash.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v)
         return v;
      else
         return v + CNT_ONE;
   endfunction

   logic                 key_db;
   logic [CNT_WIDTH-1:0] db_cnt;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] press_cnt, press_nxt;
   logic [CNT_WIDTH-1:0] gap_cnt, gap_nxt, gap_inc;
   logic                 sym_set, dash_nxt, letter_set, word_set;

   // ---- stage 0: debounce -------------------------------------------------
   // db_cnt counts consecutive cycles where key_i disagrees with key_db; any
   // agreeing cycle restarts the run. The flip lands on the DEBOUNCE_CLKS-th
   // disagreeing edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_db <= 1'b0;
         db_cnt <= CNT_ZERO;
      end else if (key_i != key_db) begin
         if (db_cnt >= DEB_LAST) begin
            key_db <= key_i;
            db_cnt <= CNT_ZERO;
         end else begin
            db_cnt <= sat_inc(db_cnt);
         end
      end else begin
         db_cnt <= CNT_ZERO;
      end
   end

   // ---- stage 1: press/gap timing FSM -------------------------------------
   assign gap_inc = sat_inc(gap_cnt);

   always_comb begin
      state_nxt  = state;
      press_nxt  = press_cnt;
      gap_nxt    = gap_cnt;
      sym_set    = 1'b0;
      dash_nxt   = symbol_dash_o;
      letter_set = 1'b0;
      word_set   = 1'b0;

      unique case (state)
         IDLE: begin
            if (key_db) begin
               state_nxt = PRESS;
               press_nxt = CNT_ONE;
            end
         end

         PRESS: begin
            if (key_db) begin
               press_nxt = sat_inc(press_cnt);
            end else begin
               // press_cnt holds the number of high cycles seen so far,
               // which is the full press length L at this point.
               state_nxt = GAP;
               gap_nxt   = CNT_ONE;
               sym_set   = 1'b1;
               dash_nxt  = (press_cnt >= DASH_TH);
            end
         end

         GAP: begin
            if (gap_cnt >= LETTER_TH) begin
               // Only reachable with a one-cycle letter gap, where the first
               // low cycle already met the threshold on entry.
               state_nxt  = LETTER_WAIT;
               letter_set = 1'b1;
               if (!key_db)
                  gap_nxt = gap_inc;
            end else if (key_db) begin
               state_nxt = PRESS;
               press_nxt = CNT_ONE;
            end else begin
               gap_nxt = gap_inc;
               if (gap_inc >= LETTER_TH) begin
                  state_nxt  = LETTER_WAIT;
                  letter_set = 1'b1;
               end
            end
         end

         LETTER_WAIT: begin
            if (key_db) begin
               state_nxt = PRESS;
               press_nxt = CNT_ONE;
            end else begin
               gap_nxt = gap_inc;
               if (gap_inc >= WORD_TH) begin
                  state_nxt = IDLE;
                  word_set  = 1'b1;
                  gap_nxt   = CNT_ZERO;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         press_cnt <= CNT_ZERO;
         gap_cnt   <= CNT_ZERO;
      end else begin
         state     <= state_nxt;
         press_cnt <= press_nxt;
         gap_cnt   <= gap_nxt;
      end
   end

   // ---- stage 2: registered event outputs ---------------------------------
   // Each pulse comes from a distinct FSM branch, so at most one is set in a
   // given cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         symbol_valid_o <= 1'b0;
         symbol_dash_o  <= 1'b0;
         letter_end_o   <= 1'b0;
         word_end_o     <= 1'b0;
      end else begin
         symbol_valid_o <= sym_set;
         symbol_dash_o  <= dash_nxt;
         letter_end_o   <= letter_set;
         word_end_o     <= word_set;
      end
   end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
module tb_morse_symbol_classifier;

   logic clk = 1'b0;
   logic reset;
   logic key_i;
   logic symbol_valid_o;
   logic symbol_dash_o;
   logic letter_end_o;
   logic word_end_o;

   int checks = 0;
   int errors = 0;

   // Pulse monitor state, updated once per cycle by tick()
   int   cyc = 0;
   int   sv_cnt, le_cnt, we_cnt;
   int   sv_first, sv_last, le_first, we_first;
   logic sv_first_dash, sv_last_dash;
   int   excl_err = 0;
   int   rel = 0;

   morse_symbol_classifier #(
      .DEBOUNCE_CLKS   (4),
      .DASH_CLKS       (12),
      .LETTER_GAP_CLKS (12),
      .WORD_GAP_CLKS   (28),
      .CNT_WIDTH       (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .key_i          (key_i),
      .symbol_valid_o (symbol_valid_o),
      .symbol_dash_o  (symbol_dash_o),
      .letter_end_o   (letter_end_o),
      .word_end_o     (word_end_o)
   );

   always #5 clk = ~clk;

   task automatic clear_mon();
      sv_cnt = 0; le_cnt = 0; we_cnt = 0;
      sv_first = -1; sv_last = -1; le_first = -1; we_first = -1;
      sv_first_dash = 1'b0; sv_last_dash = 1'b0;
   endtask

   // Advance one clock and sample outputs 1 time unit after the edge.
   task automatic tick();
      int n;
      @(posedge clk);
      #1;
      cyc++;
      n = 0;
      if (symbol_valid_o) begin
         n++;
         if (sv_cnt == 0) begin
            sv_first      = cyc;
            sv_first_dash = symbol_dash_o;
         end
         sv_cnt++;
         sv_last      = cyc;
         sv_last_dash = symbol_dash_o;
      end
      if (letter_end_o) begin
         n++;
         if (le_cnt == 0) le_first = cyc;
         le_cnt++;
      end
      if (word_end_o) begin
         n++;
         if (we_cnt == 0) we_first = cyc;
         we_cnt++;
      end
      if (n > 1) excl_err++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // key_i high for n cycles, then low; rel marks the cycle of the key_i fall.
   task automatic press(input int n);
      key_i = 1'b1;
      repeat (n) tick();
      key_i = 1'b0;
      rel = cyc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      key_i = 1'b0;
      idle(3);
      checks++;
      if ({symbol_valid_o, symbol_dash_o, letter_end_o, word_end_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000",
                  {symbol_valid_o, symbol_dash_o, letter_end_o, word_end_o});
      end
      reset = 1'b0;
      // Reset mid-press: key held 8 cycles, so the debounced press is running.
      key_i = 1'b1;
      idle(8);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({symbol_valid_o, symbol_dash_o, letter_end_o, word_end_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_midpress got %b want 0000",
                  {symbol_valid_o, symbol_dash_o, letter_end_o, word_end_o});
      end
      key_i = 1'b0;
      idle(3);
      reset = 1'b0;
      clear_mon();
      idle(40);
      checks++;
      if (sv_cnt !== 0 || le_cnt !== 0 || we_cnt !== 0) begin
         errors++;
         $display("FAIL reset_discard sv=%0d le=%0d we=%0d want 0 0 0", sv_cnt, le_cnt, we_cnt);
      end
   endtask

   task automatic test_dot();
      clear_mon();
      press(5);
      idle(40);
      checks++;
      if (sv_cnt !== 1) begin
         errors++;
         $display("FAIL dot_count got %0d want 1", sv_cnt);
      end
      checks++;
      if (sv_first - rel !== 5) begin
         errors++;
         $display("FAIL dot_latency got %0d want 5", sv_first - rel);
      end
      checks++;
      if (sv_first_dash !== 1'b0) begin
         errors++;
         $display("FAIL dot_kind got %b want 0", sv_first_dash);
      end
      checks++;
      if (le_cnt !== 1 || le_first - rel !== 16) begin
         errors++;
         $display("FAIL dot_letter_end cnt=%0d at=%0d want 1 at 16", le_cnt, le_first - rel);
      end
      checks++;
      if (we_cnt !== 1 || we_first - rel !== 32) begin
         errors++;
         $display("FAIL dot_word_end cnt=%0d at=%0d want 1 at 32", we_cnt, we_first - rel);
      end
   endtask

   task automatic test_dash_boundary();
      int   lens  [3] = '{11, 12, 40};
      logic kinds [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         clear_mon();
         press(lens[i]);
         idle(40);
         checks++;
         if (sv_cnt !== 1 || sv_first - rel !== 5 || sv_first_dash !== kinds[i]) begin
            errors++;
            $display("FAIL dash_len%0d cnt=%0d lat=%0d dash=%b want 1 5 %b",
                     lens[i], sv_cnt, sv_first - rel, sv_first_dash, kinds[i]);
         end
      end
      // Dash level is held after the pulse and must clear on reset.
      checks++;
      if (symbol_dash_o !== 1'b1) begin
         errors++;
         $display("FAIL dash_hold got %b want 1", symbol_dash_o);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (symbol_dash_o !== 1'b0) begin
         errors++;
         $display("FAIL dash_reset got %b want 0", symbol_dash_o);
      end
      idle(2);
      reset = 1'b0;
   endtask

   task automatic test_bounce();
      clear_mon();
      for (int w = 1; w <= 3; w++) begin
         key_i = 1'b1;
         idle(w);
         key_i = 1'b0;
         idle(5);
      end
      idle(40);
      checks++;
      if (sv_cnt !== 0 || le_cnt !== 0 || we_cnt !== 0) begin
         errors++;
         $display("FAIL bounce sv=%0d le=%0d we=%0d want 0 0 0", sv_cnt, le_cnt, we_cnt);
      end
   endtask

   task automatic test_letter_word();
      int r1;
      clear_mon();
      press(5);
      r1 = rel;
      idle(5);
      press(15);
      idle(40);
      checks++;
      if (sv_cnt !== 2 || sv_first - r1 !== 5 || sv_last - rel !== 5) begin
         errors++;
         $display("FAIL lw_symbols cnt=%0d lat1=%0d lat2=%0d want 2 5 5",
                  sv_cnt, sv_first - r1, sv_last - rel);
      end
      checks++;
      if (sv_first_dash !== 1'b0 || sv_last_dash !== 1'b1) begin
         errors++;
         $display("FAIL lw_kinds got %b%b want 01", sv_first_dash, sv_last_dash);
      end
      checks++;
      if (le_cnt !== 1 || le_first - rel !== 16) begin
         errors++;
         $display("FAIL lw_letter_end cnt=%0d at=%0d want 1 at 16", le_cnt, le_first - rel);
      end
      checks++;
      if (we_cnt !== 1 || we_first - rel !== 32) begin
         errors++;
         $display("FAIL lw_word_end cnt=%0d at=%0d want 1 at 32", we_cnt, we_first - rel);
      end
      idle(30);
      checks++;
      if (sv_cnt !== 2 || le_cnt !== 1 || we_cnt !== 1) begin
         errors++;
         $display("FAIL lw_silence sv=%0d le=%0d we=%0d want 2 1 1", sv_cnt, le_cnt, we_cnt);
      end
   endtask

   task automatic test_gap_interrupt();
      int r1;
      clear_mon();
      press(5);
      r1 = rel;
      idle(20);
      press(6);
      checks++;
      if (le_cnt !== 1 || le_first - r1 !== 16 || we_cnt !== 0) begin
         errors++;
         $display("FAIL gi_first_letter le=%0d at=%0d we=%0d want 1 at 16, we 0",
                  le_cnt, le_first - r1, we_cnt);
      end
      idle(40);
      checks++;
      if (sv_cnt !== 2 || sv_last - rel !== 5 || sv_last_dash !== 1'b0) begin
         errors++;
         $display("FAIL gi_second_symbol cnt=%0d lat=%0d dash=%b want 2 5 0",
                  sv_cnt, sv_last - rel, sv_last_dash);
      end
      checks++;
      if (le_cnt !== 2 || we_cnt !== 1 || we_first - rel !== 32) begin
         errors++;
         $display("FAIL gi_word_end le=%0d we=%0d at=%0d want 2 1 at 32",
                  le_cnt, we_cnt, we_first - rel);
      end
   endtask

   // Debounced rise lands on the same edge the letter threshold is reached:
   // letter_end still fires and the new 11-cycle press must count from 1 (dot).
   task automatic test_threshold_collision();
      int r1;
      clear_mon();
      press(5);
      r1 = rel;
      idle(12);
      press(11);
      idle(40);
      checks++;
      if (le_first - r1 !== 16) begin
         errors++;
         $display("FAIL tc_letter_end at=%0d want 16", le_first - r1);
      end
      checks++;
      if (sv_cnt !== 2 || sv_last_dash !== 1'b0 || sv_last - rel !== 5) begin
         errors++;
         $display("FAIL tc_new_press cnt=%0d dash=%b lat=%0d want 2 0 5",
                  sv_cnt, sv_last_dash, sv_last - rel);
      end
      checks++;
      if (le_cnt !== 2 || we_cnt !== 1) begin
         errors++;
         $display("FAIL tc_markers le=%0d we=%0d want 2 1", le_cnt, we_cnt);
      end
   endtask

   task automatic test_random();
      int run;
      clear_mon();
      excl_err = 0;
      for (int k = 0; k < 150; k++) begin
         key_i = $urandom_range(1, 0) == 1 ? 1'b1 : 1'b0;
         run = $urandom_range(20, 1);
         idle(run);
      end
      key_i = 1'b0;
      idle(50);
      checks++;
      if (excl_err !== 0) begin
         errors++;
         $display("FAIL random_exclusive overlaps=%0d want 0", excl_err);
      end
   endtask

   initial begin
      reset = 1'b1;
      key_i = 1'b0;
      clear_mon();
      test_reset();
      test_dot();
      test_dash_boundary();
      test_bounce();
      test_letter_word();
      test_gap_interrupt();
      test_threshold_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
